// File: rtl/dpsram_be_clr_if.sv
// Bus bundle for dpsram_be_clr: both RAM ports (address, write data, write
// strobe, byte enables, read enable, read data).
//   master : drives addresses, data, strobes and enables; receives read data
//   slave  : the RAM side; receives requests and drives A_DOUT / B_DOUT
interface dpsram_be_clr_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10
);
  localparam int NBYTES = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] A_ADDR;
  logic [DATA_WIDTH-1:0] A_DIN;
  logic                  A_WEN;
  logic [NBYTES-1:0]     A_WBYTE_EN;
  logic                  A_REN;
  logic [DATA_WIDTH-1:0] A_DOUT;

  logic [ADDR_WIDTH-1:0] B_ADDR;
  logic [DATA_WIDTH-1:0] B_DIN;
  logic                  B_WEN;
  logic [NBYTES-1:0]     B_WBYTE_EN;
  logic                  B_REN;
  logic [DATA_WIDTH-1:0] B_DOUT;

  modport master (
    output A_ADDR, A_DIN, A_WEN, A_WBYTE_EN, A_REN,
    output B_ADDR, B_DIN, B_WEN, B_WBYTE_EN, B_REN,
    input  A_DOUT, B_DOUT
  );

  modport slave (
    input  A_ADDR, A_DIN, A_WEN, A_WBYTE_EN, A_REN,
    input  B_ADDR, B_DIN, B_WEN, B_WBYTE_EN, B_REN,
    output A_DOUT, B_DOUT
  );
endinterface

// File: rtl/dpsram_be_clr.sv
// True dual-port synchronous RAM with per-byte write enables, selectable read
// latency (1 or 2), selectable same-port read-during-write behaviour, a clear
// engine that zero-fills the array, and write-collision detection.
// Ports:
//   CLK        rising-edge clock for all logic
//   RESET_N    asynchronous active-low reset (RAM contents are not reset)
//   CLEAR      single-cycle request to zero-fill the whole array
//   BUSY       high while the clear engine runs
//   COLLISION  one-cycle pulse after both ports wrote overlapping bytes of
//              the same address
//   bus        dpsram_be_clr_if.slave: port A / port B requests and read data
module dpsram_be_clr #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 10,
  parameter int OUT_REG        = 0,
  parameter int WRITE_MODE     = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic           CLK,
  input  logic           RESET_N,
  input  logic           CLEAR,
  output logic           BUSY,
  output logic           COLLISION,
  dpsram_be_clr_if.slave bus
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int DEPTH  = 1 << ADDR_WIDTH;

  typedef enum logic {
    ST_IDLE,
    ST_CLEARING
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clearing;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [NBYTES-1:0]     a_we;
  logic [NBYTES-1:0]     b_we;
  logic [DATA_WIDTH-1:0] a_rd;
  logic [DATA_WIDTH-1:0] b_rd;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] a_q2;
  logic [DATA_WIDTH-1:0] b_q2;

  assign clearing = (state == ST_CLEARING);
  assign BUSY     = clearing;

  assign a_we = bus.A_WBYTE_EN & {NBYTES{bus.A_WEN}};
  assign b_we = bus.B_WBYTE_EN & {NBYTES{bus.B_WEN}};

  // Clear engine: one zero word per cycle, leaves after the last address.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= (CLEAR_ON_RESET != 0) ? ST_CLEARING : ST_IDLE;
      clr_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (CLEAR) begin
            state    <= ST_CLEARING;
            clr_addr <= '0;
          end
        end
        ST_CLEARING: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == '1) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Array writes. Port B is applied before port A so that A's data lands on
  // bytes both ports enable at the same address.
  always_ff @(posedge CLK) begin
    if (clearing) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (b_we[i]) begin
          mem[bus.B_ADDR][8*i +: 8] <= bus.B_DIN[8*i +: 8];
        end
        if (a_we[i]) begin
          mem[bus.A_ADDR][8*i +: 8] <= bus.A_DIN[8*i +: 8];
        end
      end
    end
  end

  // Read data: pre-write word, optionally overlaid with the same port's own
  // enabled write bytes. The other port's write is never forwarded.
  always_comb begin
    a_rd = mem[bus.A_ADDR];
    b_rd = mem[bus.B_ADDR];
    if (WRITE_MODE != 0) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (a_we[i]) begin
          a_rd[8*i +: 8] = bus.A_DIN[8*i +: 8];
        end
        if (b_we[i]) begin
          b_rd[8*i +: 8] = bus.B_DIN[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      a_q       <= '0;
      b_q       <= '0;
      a_q2      <= '0;
      b_q2      <= '0;
      COLLISION <= 1'b0;
    end else begin
      if (bus.A_REN) begin
        a_q <= clearing ? '0 : a_rd;
      end
      if (bus.B_REN) begin
        b_q <= clearing ? '0 : b_rd;
      end
      a_q2      <= a_q;
      b_q2      <= b_q;
      COLLISION <= !clearing && (bus.A_ADDR == bus.B_ADDR) && ((a_we & b_we) != '0);
    end
  end

  assign bus.A_DOUT = (OUT_REG != 0) ? a_q2 : a_q;
  assign bus.B_DOUT = (OUT_REG != 0) ? b_q2 : b_q;

endmodule

// File: tb/tb_dpsram_be_clr.sv
// Testbench for dpsram_be_clr. Three instances share one stimulus:
//   dut0: latency 1, read-first; dut1: latency 2, write-first;
//   dut2: no clear on reset (only its BUSY after reset is observed).
// A word-level memory model predicts read data, BUSY and COLLISION each cycle;
// a vector table adds hand-derived constants for the directed scenarios.
module tb_dpsram_be_clr;

  localparam int DW    = 64;
  localparam int AW    = 4;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          clear;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_din, b_din;
  logic          a_wen, b_wen, a_ren, b_ren;
  logic [NB-1:0] a_be, b_be;
  logic          busy0, busy1, busy2, col0, col1, col2;

  dpsram_be_clr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
  dpsram_be_clr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
  dpsram_be_clr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

  assign bus0.A_ADDR = a_addr; assign bus0.A_DIN = a_din; assign bus0.A_WEN = a_wen;
  assign bus0.A_WBYTE_EN = a_be; assign bus0.A_REN = a_ren;
  assign bus0.B_ADDR = b_addr; assign bus0.B_DIN = b_din; assign bus0.B_WEN = b_wen;
  assign bus0.B_WBYTE_EN = b_be; assign bus0.B_REN = b_ren;
  assign bus1.A_ADDR = a_addr; assign bus1.A_DIN = a_din; assign bus1.A_WEN = a_wen;
  assign bus1.A_WBYTE_EN = a_be; assign bus1.A_REN = a_ren;
  assign bus1.B_ADDR = b_addr; assign bus1.B_DIN = b_din; assign bus1.B_WEN = b_wen;
  assign bus1.B_WBYTE_EN = b_be; assign bus1.B_REN = b_ren;
  assign bus2.A_ADDR = a_addr; assign bus2.A_DIN = a_din; assign bus2.A_WEN = a_wen;
  assign bus2.A_WBYTE_EN = a_be; assign bus2.A_REN = a_ren;
  assign bus2.B_ADDR = b_addr; assign bus2.B_DIN = b_din; assign bus2.B_WEN = b_wen;
  assign bus2.B_WBYTE_EN = b_be; assign bus2.B_REN = b_ren;

  dpsram_be_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(0), .WRITE_MODE(0), .CLEAR_ON_RESET(1))
    dut0 (.CLK(clk), .RESET_N(rst_n), .CLEAR(clear), .BUSY(busy0), .COLLISION(col0), .bus(bus0));
  dpsram_be_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(1), .WRITE_MODE(1), .CLEAR_ON_RESET(1))
    dut1 (.CLK(clk), .RESET_N(rst_n), .CLEAR(clear), .BUSY(busy1), .COLLISION(col1), .bus(bus1));
  dpsram_be_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(0), .WRITE_MODE(0), .CLEAR_ON_RESET(0))
    dut2 (.CLK(clk), .RESET_N(rst_n), .CLEAR(clear), .BUSY(busy2), .COLLISION(col2), .bus(bus2));

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model state
  logic [DW-1:0] m_mem [DEPTH];
  int unsigned   m_busy_left;
  logic [DW-1:0] e_a0, e_b0;   // expected read data, latency-1 read-first
  logic [DW-1:0] s_a1, s_b1;   // latency-2 write-first: word captured by a read
  logic [DW-1:0] e_a1, e_b1;   // latency-2 write-first: expected outputs
  logic          e_col;

  typedef struct {
    logic [AW-1:0] aa; logic [DW-1:0] ad; logic aw; logic [NB-1:0] abe; logic ar;
    logic [AW-1:0] ba; logic [DW-1:0] bd; logic bw; logic [NB-1:0] bbe; logic br;
    logic [3:0]    chk;   // {a0, b0, a1, b1} read-data checks enabled
    logic [DW-1:0] ea0; logic [DW-1:0] eb0; logic [DW-1:0] ea1; logic [DW-1:0] eb1;
    logic          ecol;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    a_wen = 1'b0; a_ren = 1'b0; a_be = '0; a_din = '0; a_addr = '0;
    b_wen = 1'b0; b_ren = 1'b0; b_be = '0; b_din = '0; b_addr = '0;
    clear = 1'b0;
  endtask

  task automatic model_reset();
    e_a0 = '0; e_b0 = '0; s_a1 = '0; s_b1 = '0; e_a1 = '0; e_b1 = '0;
    e_col = 1'b0;
    m_busy_left = DEPTH;
  endtask

  // Apply the rules of one clock edge to the model using the current inputs.
  task automatic model_step();
    logic [DW-1:0] old_a, old_b, new_a, new_b;
    old_a = m_mem[a_addr];
    old_b = m_mem[b_addr];
    e_a1 = s_a1;
    e_b1 = s_b1;
    if (m_busy_left != 0) begin
      if (a_ren) begin e_a0 = '0; s_a1 = '0; end
      if (b_ren) begin e_b0 = '0; s_b1 = '0; end
      e_col = 1'b0;
      m_mem[AW'(DEPTH - m_busy_left)] = '0;
      m_busy_left--;
    end else begin
      new_a = old_a;
      new_b = old_b;
      for (int i = 0; i < NB; i++) begin
        if (a_wen && a_be[i]) new_a[8*i +: 8] = a_din[8*i +: 8];
        if (b_wen && b_be[i]) new_b[8*i +: 8] = b_din[8*i +: 8];
      end
      if (a_ren) begin e_a0 = old_a; s_a1 = new_a; end
      if (b_ren) begin e_b0 = old_b; s_b1 = new_b; end
      e_col = a_wen && b_wen && (a_addr == b_addr) && ((a_be & b_be) != '0);
      for (int i = 0; i < NB; i++) begin
        if (b_wen && b_be[i]) m_mem[b_addr][8*i +: 8] = b_din[8*i +: 8];
      end
      for (int i = 0; i < NB; i++) begin
        if (a_wen && a_be[i]) m_mem[a_addr][8*i +: 8] = a_din[8*i +: 8];
      end
      if (clear) m_busy_left = DEPTH;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("dut0 A_DOUT", bus0.A_DOUT, e_a0);
    check("dut0 B_DOUT", bus0.B_DOUT, e_b0);
    check("dut1 A_DOUT", bus1.A_DOUT, e_a1);
    check("dut1 B_DOUT", bus1.B_DOUT, e_b1);
    check1("dut0 BUSY", busy0, m_busy_left != 0);
    check1("dut1 BUSY", busy1, m_busy_left != 0);
    check1("dut0 COLLISION", col0, e_col);
    check1("dut1 COLLISION", col1, e_col);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " dut0 A_DOUT"}, bus0.A_DOUT, '0);
    check({tag, " dut0 B_DOUT"}, bus0.B_DOUT, '0);
    check({tag, " dut1 A_DOUT"}, bus1.A_DOUT, '0);
    check({tag, " dut1 B_DOUT"}, bus1.B_DOUT, '0);
    check1({tag, " dut0 BUSY"}, busy0, 1'b1);
    check1({tag, " dut1 BUSY"}, busy1, 1'b1);
    check1({tag, " dut2 BUSY"}, busy2, 1'b0);
    check1({tag, " dut0 COLLISION"}, col0, 1'b0);
  endtask

  // Counts cycles with BUSY high, starting from the current sample.
  task automatic count_busy(input string name, input logic drop_write, output int unsigned n);
    n = 0;
    while (busy0 && n < 100) begin
      n++;
      idle_inputs();
      if (drop_write && n == 3) begin
        a_wen = 1'b1; a_addr = '0; a_din = 64'h5555_5555_5555_5555; a_be = '1;
      end
      if (drop_write && n == 6) clear = 1'b1;
      cycle();
    end
    idle_inputs();
    check(name, 64'(n), 64'(DEPTH));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] ones, w, aa, r1, c1, c2, p11, p22, p33, p44;
    int unsigned n;

    ones = '1;
    w    = 64'h1122_3344_5566_7788;
    aa   = 64'hAAAA_AAAA_AAAA_AAAA;
    r1   = 64'hFFFF_FFFF_5566_7788;
    c1   = 64'h0000_0000_0022_1111;
    c2   = 64'h0000_0000_0022_4433;
    p11  = 64'h1111_1111_1111_1111;
    p22  = 64'h2222_2222_2222_2222;
    p33  = 64'h3333_3333_3333_3333;
    p44  = 64'h4444_4444_4444_4444;

    vecs[0]  = '{4'd5, ones, 1'b1, 8'hFF, 1'b0, 4'd0, '0, 1'b0, 8'h00, 1'b0, 4'b0000, '0, '0, '0, '0, 1'b0};
    vecs[1]  = '{4'd5, w,    1'b1, 8'h0F, 1'b0, 4'd0, '0, 1'b0, 8'h00, 1'b0, 4'b0000, '0, '0, '0, '0, 1'b0};
    vecs[2]  = '{4'd0, '0,   1'b0, 8'h00, 1'b0, 4'd5, '0, 1'b0, 8'h00, 1'b1, 4'b0100, '0, r1, '0, '0, 1'b0};
    vecs[3]  = '{4'd0, '0,   1'b0, 8'h00, 1'b0, 4'd0, '0, 1'b0, 8'h00, 1'b0, 4'b0101, '0, r1, '0, r1, 1'b0};
    vecs[4]  = '{4'd7, aa,   1'b1, 8'hFF, 1'b1, 4'd7, '0, 1'b0, 8'h00, 1'b1, 4'b1101, '0, '0, '0, r1, 1'b0};
    vecs[5]  = '{4'd0, '0,   1'b0, 8'h00, 1'b0, 4'd0, '0, 1'b0, 8'h00, 1'b0, 4'b1111, '0, '0, aa, '0, 1'b0};
    vecs[6]  = '{4'd3, p11,  1'b1, 8'h03, 1'b0, 4'd3, p22, 1'b1, 8'h06, 1'b0, 4'b1111, '0, '0, aa, '0, 1'b1};
    vecs[7]  = '{4'd3, '0,   1'b0, 8'h00, 1'b1, 4'd3, '0, 1'b0, 8'h00, 1'b1, 4'b1111, c1, c1, aa, '0, 1'b0};
    vecs[8]  = '{4'd3, p33,  1'b1, 8'h01, 1'b0, 4'd3, p44, 1'b1, 8'h02, 1'b0, 4'b1111, c1, c1, c1, c1, 1'b0};
    vecs[9]  = '{4'd3, '0,   1'b0, 8'h00, 1'b1, 4'd0, '0, 1'b0, 8'h00, 1'b0, 4'b1111, c2, c1, c1, c1, 1'b0};
    vecs[10] = '{4'd0, '0,   1'b0, 8'h00, 1'b0, 4'd0, '0, 1'b0, 8'h00, 1'b0, 4'b1111, c2, c1, c2, c1, 1'b0};

    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    // Reset, then automatic clear of all 16 words
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    model_reset();
    rst_n = 1'b1;
    count_busy("busy length after reset", 1'b0, n);

    // Every address reads back zero on both ports
    for (int i = 0; i < DEPTH; i++) begin
      a_ren = 1'b1; a_addr = AW'(i);
      b_ren = 1'b1; b_addr = AW'(DEPTH - 1 - i);
      cycle();
    end
    idle_inputs();
    cycle();

    // Directed vectors: byte-enable write, latency, read-during-write, collision
    for (int r = 0; r < 11; r++) begin
      a_addr = vecs[r].aa; a_din = vecs[r].ad; a_wen = vecs[r].aw; a_be = vecs[r].abe; a_ren = vecs[r].ar;
      b_addr = vecs[r].ba; b_din = vecs[r].bd; b_wen = vecs[r].bw; b_be = vecs[r].bbe; b_ren = vecs[r].br;
      clear = 1'b0;
      cycle();
      if (vecs[r].chk[3]) check($sformatf("vec%0d dut0 A", r), bus0.A_DOUT, vecs[r].ea0);
      if (vecs[r].chk[2]) check($sformatf("vec%0d dut0 B", r), bus0.B_DOUT, vecs[r].eb0);
      if (vecs[r].chk[1]) check($sformatf("vec%0d dut1 A", r), bus1.A_DOUT, vecs[r].ea1);
      if (vecs[r].chk[0]) check($sformatf("vec%0d dut1 B", r), bus1.B_DOUT, vecs[r].eb1);
      check1($sformatf("vec%0d COLLISION", r), col0, vecs[r].ecol);
    end
    idle_inputs();

    // Clear on request: write during clear is dropped, second CLEAR ignored
    clear = 1'b1;
    cycle();
    count_busy("busy length with re-CLEAR", 1'b1, n);
    a_ren = 1'b1; a_addr = '0;
    cycle();
    check("addr0 after dropped write", bus0.A_DOUT, '0);
    idle_inputs();

    // Reset in the middle of a clear
    a_ren = 1'b1; a_addr = 4'd5; b_ren = 1'b1; b_addr = 4'd3;
    cycle();
    idle_inputs();
    cycle();
    clear = 1'b1;
    cycle();
    idle_inputs();
    repeat (8) cycle();
    rst_n = 1'b0;
    #1;
    check_reset_state("mid-clear reset");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    count_busy("busy length after mid-clear reset", 1'b0, n);

    // Randomised traffic, mostly on a few addresses to provoke overlaps
    for (int k = 0; k < 1500; k++) begin
      a_addr = AW'($urandom_range(0, (k % 3 == 0) ? DEPTH - 1 : 3));
      b_addr = AW'($urandom_range(0, (k % 3 == 0) ? DEPTH - 1 : 3));
      a_din  = {$urandom, $urandom};
      b_din  = {$urandom, $urandom};
      a_wen  = 1'($urandom_range(0, 1));
      b_wen  = 1'($urandom_range(0, 1));
      a_be   = NB'($urandom);
      b_be   = NB'($urandom);
      a_ren  = 1'($urandom_range(0, 1));
      b_ren  = 1'($urandom_range(0, 1));
      clear  = ($urandom_range(0, 299) == 0);
      cycle();
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dpsram_be_clr.md
Name: dpsram_be_clr

Overview:
- Parametrised true dual-port synchronous RAM with per-byte write enables, configurable read latency and same-port read-during-write mode.
- Adds a built-in clear engine that zero-fills the array after reset and on request, plus write-collision detection.
- Single clock domain; generic successor of the fixed 64x1024 byte-enabled DPSRAM wrapper, used for digitizer sample/event buffers of varying geometry.

Parameters:
- DATA_WIDTH, 64, word width in bits; must be a multiple of 8; NBYTES = DATA_WIDTH/8.
- ADDR_WIDTH, 10, address bits; depth = 2**ADDR_WIDTH.
- OUT_REG, 0, 0 = read latency 1 cycle; 1 = extra output register, latency 2.
- WRITE_MODE, 0, same-port read during write: 0 = read-first (old data), 1 = write-first (new data merged per byte enable).
- CLEAR_ON_RESET, 1, 1 = clear engine starts automatically on reset release.

Ports:
- CLK  in  1  clock, all logic rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- CLEAR  in  1  single-cycle request to zero-fill the whole array.
- BUSY  out  1  high while clear engine runs.
- COLLISION  out  1  one-cycle pulse: both ports wrote overlapping bytes at the same address.
- A_ADDR / B_ADDR  in  ADDR_WIDTH  port addresses.
- A_DIN / B_DIN  in  DATA_WIDTH  write data.
- A_WEN / B_WEN  in  1  write strobe.
- A_WBYTE_EN / B_WBYTE_EN  in  NBYTES  byte enables; effective byte write = WEN & WBYTE_EN[i].
- A_REN / B_REN  in  1  read enable.
- A_DOUT / B_DOUT  out  DATA_WIDTH  read data.

Behaviour:
- Reset (RESET_N low, async): A_DOUT=B_DOUT=0, COLLISION=0, pipeline registers 0, clear address counter 0. FSM enters CLEARING if CLEAR_ON_RESET=1 (BUSY=1 immediately), else IDLE (BUSY=0). RAM contents are not reset by RESET_N itself.
- FSM IDLE: CLEAR=1 -> CLEARING next cycle, counter=0, BUSY=1. CLEAR is ignored while already CLEARING (no restart).
- FSM CLEARING: writes all-zero word to counter address each cycle; counter increments. After the write at address 2**ADDR_WIDTH-1 -> IDLE, BUSY=0 next cycle. Total BUSY duration = 2**ADDR_WIDTH cycles.
- While BUSY: port writes dropped; reads not performed; DOUT registers load 0 when REN=1 and hold otherwise; COLLISION held 0.
- Reset asserted mid-clear: abort immediately; restart from address 0 on release if CLEAR_ON_RESET=1.
- Read: REN=1 at edge N -> DOUT valid after edge N+1 (OUT_REG=0) or edge N+2 (OUT_REG=1). REN=0: first-stage register holds. The OUT_REG stage always follows the first stage.
- Write: byte i of mem[ADDR] updated at the edge where WEN & WBYTE_EN[i] = 1. WEN=1 with WBYTE_EN=0 writes nothing.
- Same-port read+write at same address: WRITE_MODE=0 returns pre-write word; WRITE_MODE=1 returns the new bytes where enabled, old bytes elsewhere.
- Cross-port read of an address the other port writes in the same cycle: always returns old data, regardless of WRITE_MODE.
- Both ports write same address same cycle: port A wins on bytes enabled by both; bytes enabled by only one port take that port's data. COLLISION=1 on the following cycle iff (A_WBYTE_EN & B_WBYTE_EN) != 0 and both WEN=1.
- Address wrap: none needed; full ADDR_WIDTH range is valid.

Test Plan:
- Reset with CLEAR_ON_RESET=1, ADDR_WIDTH=4 -> BUSY=1 for exactly 16 cycles after release; then reads of all 16 addresses return 0.
- Port A writes 0x1122334455667788 to addr 5 with WBYTE_EN=0x0F, prior content 0xFFFF...FF -> port B read of addr 5 returns 0xFFFFFFFF55667788. Data appears 1 cycle after REN with OUT_REG=0 and 2 cycles with OUT_REG=1.
- Same-port A write 0xAA..AA, full enables, plus read at addr 7 holding 0x0 -> WRITE_MODE=0 gives 0x0; WRITE_MODE=1 gives 0xAA..AA. Same-cycle B read of addr 7 gives 0x0 in both modes.
- Both ports write addr 3: A=0x1111..., BE=0x03; B=0x2222..., BE=0x06 -> bytes0-1=0x11, byte2=0x22, other bytes unchanged; COLLISION pulses 1 cycle. Repeat with BE A=0x01, B=0x02 -> no COLLISION.
- CLEAR pulse, then at cycle 3 of clear: A write 0x55.. to addr 0 -> dropped; mem stays 0. A second CLEAR during BUSY does not extend BUSY beyond 2**ADDR_WIDTH cycles.
- RESET_N low at clear address 8 -> DOUT=0 and BUSY=1 immediately; on release BUSY lasts a full 2**ADDR_WIDTH cycles again.
